// File: rtl/pc_sequencer.sv
// Two-phase PC sequencer: FETCH/EXEC per instruction, with exception entry and halt.
// In: clk, reset, stall, branch, zero, jump, illegal_op, imm16, target26. Out: PC, epc, cause, exec_phase, halted.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] EXC_VECTOR = 32'd88,
  parameter logic [31:0] MEM_LIMIT  = 32'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        illegal_op,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic [31:0] PC,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        exec_phase,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    EXC   = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        inh_q, inh_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] next_pc;
  logic [32:0] next_end;
  logic        addr_fault;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign jmp_tgt  = {pc_plus4[31:28], target26, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jmp_tgt;
    end else if (branch && zero) begin
      next_pc = br_tgt;
    end
  end

  // Last byte of the fetched word must lie inside memory;
  // 33-bit sum so a wrap near 2^32 still counts as a fault.
  assign next_end   = {1'b0, next_pc} + 33'd3;
  assign addr_fault = (next_pc[1:0] != 2'b00) ||
                      (next_end > {1'b0, MEM_LIMIT});

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    inh_d   = inh_q;
    unique case (state_q)
      FETCH: begin
        if (!stall) state_d = EXEC;
      end
      EXEC: begin
        if (!stall) begin
          if (illegal_op || addr_fault) begin
            epc_d   = pc_q;
            cause_d = illegal_op ? 2'b01 : 2'b10;
            state_d = inh_q ? HALT : EXC;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      EXC: begin
        pc_d    = EXC_VECTOR;
        inh_d   = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      cause_q <= 2'b00;
      inh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      inh_q   <= inh_d;
    end
  end

  assign PC         = pc_q;
  assign epc        = epc_q;
  assign cause      = cause_q;
  assign exec_phase = (state_q == EXEC);
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
// Hand-computed PC/epc/cause expectations checked with immediate assertions.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        illegal_op;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] PC;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        exec_phase;
  logic        halted;

  int passed;
  int total;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .branch     (branch),
    .zero       (zero),
    .jump       (jump),
    .illegal_op (illegal_op),
    .imm16      (imm16),
    .target26   (target26),
    .PC         (PC),
    .epc        (epc),
    .cause      (cause),
    .exec_phase (exec_phase),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr();
    branch     = 1'b0;
    zero       = 1'b0;
    jump       = 1'b0;
    illegal_op = 1'b0;
    imm16      = 16'd0;
    target26   = 26'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // From FETCH: one FETCH edge, then the EXEC edge with these decode inputs.
  task automatic run(input logic b, input logic z, input logic j,
                     input logic ill, input logic [15:0] im,
                     input logic [25:0] tg);
    branch     = b;
    zero       = z;
    jump       = j;
    illegal_op = ill;
    imm16      = im;
    target26   = tg;
    step();
    step();
    clr();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    stall  = 1'b0;
    clr();
    step();

    // Reset state and free-running sequence
    do_reset();
    chk("rst_pc", PC, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_cause", {30'd0, cause}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("seq0_pc", PC, 32'd0);
    chk("seq0_ex", {31'd0, exec_phase}, 32'd0);
    step();
    chk("seq1_pc", PC, 32'd0);
    chk("seq1_ex", {31'd0, exec_phase}, 32'd1);
    step();
    chk("seq2_pc", PC, 32'd4);
    chk("seq2_ex", {31'd0, exec_phase}, 32'd0);
    step();
    chk("seq3_pc", PC, 32'd4);
    chk("seq3_ex", {31'd0, exec_phase}, 32'd1);
    step();
    chk("seq4_pc", PC, 32'd8);
    step();
    chk("seq5_pc", PC, 32'd8);

    // Branch taken / not taken at PC=76
    do_reset();
    run(0, 0, 1, 0, 16'd0, 26'd19);
    chk("jmp_to76", PC, 32'd76);
    run(1, 1, 0, 0, 16'd1, 26'd0);
    chk("br_taken", PC, 32'd84);
    do_reset();
    run(0, 0, 1, 0, 16'd0, 26'd19);
    run(1, 0, 0, 0, 16'd1, 26'd0);
    chk("br_not_taken", PC, 32'd80);
    run(0, 0, 1, 0, 16'd0, 26'd17);
    chk("jmp_to68", PC, 32'd68);

    // Jump beats taken branch
    do_reset();
    run(0, 0, 1, 0, 16'd0, 26'd20);
    chk("jmp_to80", PC, 32'd80);
    run(1, 1, 1, 0, 16'd1, 26'd17);
    chk("jmp_prio", PC, 32'd68);

    // Illegal opcode, handler entry, then halt
    do_reset();
    run(0, 0, 1, 0, 16'd0, 26'd22);
    chk("jmp_to88", PC, 32'd88);
    run(0, 0, 0, 1, 16'd0, 26'd0);
    chk("ill_epc", epc, 32'd88);
    chk("ill_cause", {30'd0, cause}, 32'd1);
    chk("ill_pc_hold", PC, 32'd88);
    chk("ill_exc_ex", {31'd0, exec_phase}, 32'd0);
    chk("ill_exc_hlt", {31'd0, halted}, 32'd0);
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk("exc_vec_pc", PC, 32'd88);
    chk("exc_to_fetch", {31'd0, exec_phase}, 32'd0);
    run(0, 0, 0, 1, 16'd0, 26'd0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_epc", epc, 32'd88);
    chk("halt_cause", {30'd0, cause}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      stall    = i[0];
      jump     = 1'b1;
      target26 = 26'($urandom);
      step();
      chk("halt_pc", PC, 32'd88);
      chk("halt_hold", {31'd0, halted}, 32'd1);
    end
    clr();

    // Reset out of HALT wins over stall
    stall = 1'b1;
    do_reset();
    stall = 1'b0;
    chk("halt_rst_pc", PC, 32'd0);
    chk("halt_rst_hlt", {31'd0, halted}, 32'd0);
    chk("halt_rst_cause", {30'd0, cause}, 32'd0);

    // Address fault past MEM_LIMIT
    do_reset();
    run(0, 0, 1, 0, 16'd0, 26'd24);
    chk("jmp_to96", PC, 32'd96);
    run(0, 0, 0, 0, 16'd0, 26'd0);
    chk("af_cause", {30'd0, cause}, 32'd2);
    chk("af_epc", epc, 32'd96);
    chk("af_pc_hold", PC, 32'd96);
    step();
    chk("af_vec_pc", PC, 32'd88);
    run(0, 0, 0, 0, 16'd0, 26'd0);
    chk("af_seq_pc", PC, 32'd92);
    chk("cause_sticky", {30'd0, cause}, 32'd2);

    // Backward branch to 0 is legal
    do_reset();
    run(1, 1, 0, 0, 16'hFFFF, 26'd0);
    chk("br_neg_pc", PC, 32'd0);
    chk("br_neg_cause", {30'd0, cause}, 32'd0);
    chk("br_neg_ex", {31'd0, exec_phase}, 32'd0);

    // Stall held in EXEC
    do_reset();
    step();
    stall = 1'b1;
    jump  = 1'b1;
    target26 = 26'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", PC, 32'd0);
      chk("stall_ex", {31'd0, exec_phase}, 32'd1);
    end
    stall = 1'b0;
    clr();
    step();
    chk("unstall_pc", PC, 32'd4);
    chk("unstall_ex", {31'd0, exec_phase}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: PC value loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'd88: PC value loaded on exception entry.
REQ-003 SHALL have parameter MEM_LIMIT, default 32'd100: highest valid instruction-memory byte address.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1: holds the sequencer in FETCH or EXEC.
REQ-007 SHALL have port branch, input, 1: decoded beq.
REQ-008 SHALL have port zero, input, 1: ALU equality result.
REQ-009 SHALL have port jump, input, 1: decoded j.
REQ-010 SHALL have port illegal_op, input, 1: undefined opcode.
REQ-011 SHALL have port imm16, input, 16: instruction bits 15:0.
REQ-012 SHALL have port target26, input, 26: instruction bits 25:0.
REQ-013 SHALL have port PC, output, 32: fetch address to instruction memory.
REQ-014 SHALL have port epc, output, 32: address of the faulting instruction.
REQ-015 SHALL have port cause, output, 2: exception cause (00 none, 01 illegal opcode, 10 address fault).
REQ-016 SHALL have port exec_phase, output, 1: high while in EXEC; decode inputs are sampled only then.
REQ-017 SHALL have port halted, output, 1: high in HALT.

Function
REQ-018 SHALL implement FSM states FETCH, EXEC, EXC, HALT; state, PC, epc, cause, in_handler SHALL be registers.
REQ-019 FETCH SHALL hold PC stable for one cycle, then go to EXEC (instruction memory latches during this edge).
REQ-020 EXEC SHALL compute the next PC and go to FETCH with PC updated; one instruction completes every 2 cycles.
REQ-021 Next-PC priority in EXEC SHALL be: illegal_op, then jump, then branch&zero, then sequential.
REQ-022 Sequential next PC SHALL be PC+4, modulo 2^32.
REQ-023 Jump target SHALL be {PC_plus4[31:28], target26, 2'b00}.
REQ-024 Taken branch SHALL target PC+4 + (sign-extended imm16 << 2), 32-bit wrap, no overflow flag.
REQ-025 illegal_op in EXEC SHALL set epc=PC, cause=01, enter EXC, and leave PC unchanged that cycle.
REQ-026 A computed next PC with bits[1:0]!=0 or next+3 > MEM_LIMIT SHALL set epc=PC, cause=10, enter EXC.
REQ-027 EXC SHALL last one cycle: PC<=EXC_VECTOR, in_handler<=1, next state FETCH.
REQ-028 Any exception condition while in_handler=1 SHALL enter HALT instead of EXC, and SHALL still update epc and cause.
REQ-029 HALT SHALL freeze PC, epc and cause, drive halted=1, and be exited only by reset.
REQ-030 stall=1 in FETCH or EXEC SHALL hold state and all registers; stall SHALL be ignored in EXC and HALT.
REQ-031 Decode inputs SHALL be ignored outside EXEC.
REQ-032 cause SHALL keep its last value until the next exception or reset; a successful instruction SHALL NOT clear it.

Reset
REQ-033 reset=1 at a clock edge SHALL force state FETCH, PC=RESET_PC, epc=0, cause=00, in_handler=0, halted=0, exec_phase=0, from any state including mid-EXEC and HALT.
REQ-034 reset SHALL take priority over stall and all exception conditions.

Verification
REQ-035 Bench SHALL check: reset, then 6 cycles with no decode inputs -> PC sequence 0,0,4,4,8,8; exec_phase toggles 0,1,0,1.
REQ-036 Bench SHALL check: PC=76, EXEC with branch=1, zero=1, imm16=1 -> PC=84; with zero=0 -> PC=80.
REQ-037 Bench SHALL check: PC=80, EXEC with jump=1, target26=17 -> PC=68; with jump=1 and branch=1 together -> jump wins, PC=68.
REQ-038 Bench SHALL check: PC=88 with illegal_op=1 -> epc=88, cause=01, one EXC cycle, then PC=88; a second illegal_op -> halted=1, PC frozen at 88 for 10 cycles.
REQ-039 Bench SHALL check: PC=96, sequential step -> next 100, 103>100 -> cause=10, epc=96; branch imm16=16'hFFFF at PC=0 -> target 0, no fault.
REQ-040 Bench SHALL check: stall=1 for 3 cycles in EXEC -> PC and state unchanged; reset asserted in HALT -> PC=0, halted=0 next cycle.
